// File: rtl/apb_harb_arbiter_if.sv
// rtl/apb_harb_arbiter_if.sv - arbiter-to-bridge AHB-style bus bundle
interface apb_harb_arbiter_if;
  logic        harb_apb_hsel;
  logic [31:0] harb_xx_haddr;
  logic        harb_xx_hwrite;
  logic [31:0] harb_xx_hwdata;
  logic        apb_harb_hready;
  logic [31:0] apb_harb_hrdata;
  logic [1:0]  apb_harb_hresp;

  // Arbiter side: issues the address phase and write data, consumes the response.
  modport master (
    output harb_apb_hsel,
    output harb_xx_haddr,
    output harb_xx_hwrite,
    output harb_xx_hwdata,
    input  apb_harb_hready,
    input  apb_harb_hrdata,
    input  apb_harb_hresp
  );

  // Bridge side.
  modport slave (
    input  harb_apb_hsel,
    input  harb_xx_haddr,
    input  harb_xx_hwrite,
    input  harb_xx_hwdata,
    output apb_harb_hready,
    output apb_harb_hrdata,
    output apb_harb_hresp
  );
endinterface

// File: rtl/apb_harb_arbiter.sv
// rtl/apb_harb_arbiter.sv - two-master round-robin arbiter and sequencer in front of the AHB-to-APB bridge
module apb_harb_arbiter #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic               hclk,
  input  logic               hrst_b,
  input  logic               m0_req,
  input  logic [31:0]        m0_addr,
  input  logic               m0_write,
  input  logic [31:0]        m0_wdata,
  output logic               m0_ack,
  output logic [31:0]        m0_rdata,
  output logic               m0_err,
  input  logic               m1_req,
  input  logic [31:0]        m1_addr,
  input  logic               m1_write,
  input  logic [31:0]        m1_wdata,
  output logic               m1_ack,
  output logic [31:0]        m1_rdata,
  output logic               m1_err,
  apb_harb_arbiter_if.master bus,
  output logic               arb_busy,
  output logic               arb_grant
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t             state;
  logic               last_grant;
  logic [CNT_W-1:0]   cnt;
  logic               drain;

  logic               pick;
  logic [31:0]        pick_addr;
  logic               pick_write;
  logic [31:0]        pick_wdata;

  logic               timeout;
  logic               cpl;
  logic [31:0]        cpl_rdata;
  logic               cpl_err;

  // Round-robin choice: a lone requester wins, a tie goes to the master not served last.
  always_comb begin
    pick = m1_req;
    if (m0_req && m1_req) begin
      pick = ~last_grant;
    end
    pick_addr  = pick ? m1_addr  : m0_addr;
    pick_write = pick ? m1_write : m0_write;
    pick_wdata = pick ? m1_wdata : m0_wdata;
  end

  // Data-phase outcome: normal completion on hready, abort once the watchdog expires.
  always_comb begin
    timeout   = ~bus.apb_harb_hready && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    cpl       = bus.apb_harb_hready || timeout;
    cpl_rdata = (bus.apb_harb_hready && !bus.harb_xx_hwrite) ? bus.apb_harb_hrdata : 32'h0;
    cpl_err   = bus.apb_harb_hready ? (bus.apb_harb_hresp != 2'b00) : 1'b1;
  end

  assign arb_busy = (state != IDLE);

  // Transfer sequencer: grant, one address phase, watched data phase, ack pulse, optional drain.
  always_ff @(posedge hclk) begin
    if (!hrst_b) begin
      state              <= IDLE;
      last_grant         <= 1'b1;
      arb_grant          <= 1'b0;
      cnt                <= '0;
      drain              <= 1'b0;
      bus.harb_apb_hsel  <= 1'b0;
      bus.harb_xx_haddr  <= 32'h0;
      bus.harb_xx_hwrite <= 1'b0;
      bus.harb_xx_hwdata <= 32'h0;
      m0_ack             <= 1'b0;
      m0_rdata           <= 32'h0;
      m0_err             <= 1'b0;
      m1_ack             <= 1'b0;
      m1_rdata           <= 32'h0;
      m1_err             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.apb_harb_hready && (m0_req || m1_req)) begin
            last_grant         <= pick;
            arb_grant          <= pick;
            bus.harb_xx_haddr  <= pick_addr;
            bus.harb_xx_hwrite <= pick_write;
            bus.harb_xx_hwdata <= pick_wdata;
            bus.harb_apb_hsel  <= 1'b1;
            state              <= ADDR;
          end
        end
        ADDR: begin
          bus.harb_apb_hsel <= 1'b0;
          cnt               <= '0;
          state             <= DATA;
        end
        DATA: begin
          if (cpl) begin
            if (arb_grant) begin
              m1_ack   <= 1'b1;
              m1_rdata <= cpl_rdata;
              m1_err   <= cpl_err;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= cpl_rdata;
              m0_err   <= cpl_err;
            end
            // An aborted transfer leaves the bridge mid-access; wait it out before re-granting.
            drain <= timeout;
            state <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          drain  <= 1'b0;
          state  <= drain ? DRAIN : IDLE;
        end
        DRAIN: begin
          if (bus.apb_harb_hready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_harb_arbiter.md
Name: apb_harb_arbiter

Overview:
- Two-requester arbiter and sequencer placed in front of the AHB-to-APB bridge.
- Takes simple req/ack transfers from two masters (m0 = CPU system port, m1 = debug/DMA port) and grants them round-robin.
- Issues one AHB-style address phase to the bridge, holds write data through the data phase, and returns read data, ack and error to the granted master.
- Adds a watchdog that aborts a stalled transfer.

Parameters:
- TIMEOUT_CYC, 16, max data-phase cycles with hready low before abort (>=4).
- CNT_W, 5, watchdog counter width; must hold TIMEOUT_CYC.

Ports:
- hclk  in  1  clock
- hrst_b  in  1  reset, synchronous, active-low
- m0_req / m1_req  in  1  transfer request, level; held until ack
- m0_addr / m1_addr  in  32  address, stable while req=1
- m0_write / m1_write  in  1  1=write, 0=read
- m0_wdata / m1_wdata  in  32  write data, stable while req=1
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read data, valid with ack
- m0_err / m1_err  out  1  error, valid with ack
- harb_apb_hsel  out  1  address-phase select to bridge
- harb_xx_haddr  out  32  address to bridge
- harb_xx_hwrite  out  1  direction to bridge
- harb_xx_hwdata  out  32  write data to bridge
- apb_harb_hready  in  1  bridge ready
- apb_harb_hrdata  in  32  bridge read data
- apb_harb_hresp  in  2  bridge response; nonzero = error
- arb_busy  out  1  state != IDLE
- arb_grant  out  1  index of the current/last granted master

Behaviour:
- Clocking and reset: all state on the hclk rising edge. Synchronous reset when hrst_b=0, including mid-transfer.
- Reset values: state=IDLE; all outputs 0; last_grant=1, so m0 wins the first tie.
- FSM states: IDLE, ADDR, DATA, RESP, DRAIN (3-bit).
- IDLE:
  - Grant and go to ADDR when apb_harb_hready=1 and any req=1.
  - One requester: grant it. Both: grant !last_grant.
  - Update last_grant and arb_grant, and register the granted master's addr/write/wdata onto harb_xx_*.
- ADDR: exactly one cycle with harb_apb_hsel=1. Always goes to DATA; counter cleared.
- DATA:
  - hsel=0; haddr, hwrite and hwdata are held unchanged.
  - If hready=1: capture apb_harb_hrdata (reads only; writes return 0); err=(hresp!=0); go to RESP.
  - Else if counter==TIMEOUT_CYC-1: rdata=0, err=1, go to RESP with drain flag set.
  - Else increment counter.
  - The first DATA cycle always has hready=0 from the bridge; an hready=1 there is still accepted.
- RESP:
  - One cycle: granted mX_ack=1 with mX_rdata/mX_err. The other master's ack=0.
  - Go to DRAIN if drain flag set, else IDLE.
  - Requests are not evaluated in RESP; a requester drops or replaces req the cycle after ack.
- DRAIN: hsel=0; wait for hready=1, then IDLE. No new grant while the bridge is still busy.
- Latency from req seen in IDLE to ack:
  - read: ack 4 cycles later (ADDR, R_SELECT, ENABLE, RESP);
  - write: 5 cycles later.
- Back-to-back: at best, a new ADDR comes 1 cycle after RESP (via IDLE).
- Req dropped after grant: the transfer completes and ack is still pulsed.
- m*_rdata/m*_err hold their value between acks; only the granted master's copy updates.

Test Plan:
- m0 read 0x40011004, bridge returns 0xA5A5_0001 at ENABLE -> hsel high 1 cycle at T+1, m0_ack at T+4, m0_rdata=0xA5A5_0001, m0_err=0.
- m1 write 0x40019000 data 0x1234_5678 -> hwdata stable from ADDR through ENABLE, m1_ack at T+5, bridge pwdata=0x1234_5678.
- m0 and m1 request simultaneously and continuously for 4 transfers -> grants m0,m1,m0,m1; each ack pulses exactly once per transfer.
- Hold hready low for 20 cycles (TIMEOUT_CYC=16) -> ack+err=1, rdata=0 at the 16th DATA cycle +1; DRAIN until hready=1; no hsel meanwhile.
- hresp=2'b01 at completion -> err=1 with ack.
- Reset asserted in DATA -> next cycle state IDLE, all outputs 0, last_grant=1; a subsequent tie goes to m0.
